rf_writeback_ctrl: RTL and testbench
====================================

# rf_writeback_ctrl

Write-side controller for the 16x16 register file. Accepts writeback results from the ALU and memory pipeline stages through valid/ready handshakes and buffers them in a small FIFO. Drains one result per cycle onto the register file's single write port (WAddr/WData/Wen). Also keeps a per-register pending-write scoreboard that stalls issue on RAW hazards the register file's same-cycle write bypass cannot cover.

## Interface
- DW, 16, data width of results and the register-file write port
- DEPTH, 4, writeback FIFO entries; power of two, ≥2

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- AluValid  in  1  ALU result valid
- AluAddr  in  4  ALU destination register
- AluData  in  DW  ALU result
- AluReady  out  1  ALU result accepted when AluValid && AluReady
- MemValid  in  1  load result valid
- MemAddr  in  4  load destination register
- MemData  in  DW  load result
- MemReady  out  1  load result accepted when MemValid && MemReady
- WAddr  out  4  register-file write address (registered)
- WData  out  DW  register-file write data (registered)
- Wen  out  1  register-file write enable (registered)
- IssueValid  in  1  an instruction is presented for issue
- IssueDest  in  4  destination of the issuing instruction; 0 means none
- IssueUsesR1, IssueUsesR2  in  1 each  instruction reads RAddr1 / RAddr2
- RAddr1, RAddr2  in  4 each  source registers of the issuing instruction
- Stall  out  1  combinational; the issue is not accepted this cycle
- BusyVec  out  16  bit r = 1 when register r has a pending write

## Operation
- FIFO and handshake
  - count = registered FIFO occupancy.
  - AluReady = MemReady = (count ≤ DEPTH-2). Both sources may push in the same cycle.
  - On a simultaneous push, the Mem entry is enqueued ahead of the Alu entry.
  - An accepted push with address 0 is consumed but not enqueued.
- Drain
  - At each edge, if count > 0 (pre-edge), the head is popped into WAddr/WData and Wen ← 1; otherwise Wen ← 0 and WAddr/WData hold.
  - Push and pop in the same edge are legal; count ← count + pushes − pop.
  - Entries drain strictly in FIFO order.
- Scoreboard
  - One 2-bit counter cnt[r] for r = 1..15; cnt[0] is always 0. BusyVec[r] = (cnt[r] ≠ 0).
  - Issue is accepted when IssueValid && !Stall. An accepted issue with IssueDest ≠ 0 increments cnt[IssueDest].
  - The edge ending a cycle with Wen=1 decrements cnt[WAddr]; this is the same edge at which the register file commits the write. No decrement at 0.
  - Increment and decrement of the same register in the same edge leave it unchanged.
- Hazard term for source s ∈ {1,2}
  - hz_s = IssueUsesRs && RAddrs ≠ 0 && cnt[RAddrs] ≠ 0 && !(Wen && WAddr == RAddrs && cnt[RAddrs] == 1).
  - The final clause exists because the register file forwards WData to a same-cycle read of WAddr.
- Stall = IssueValid && (hz_1 || hz_2 || (IssueDest ≠ 0 && cnt[IssueDest] == 3)).

## Timing
- Reset (async, any cycle, including mid-drain):
  - Wen=0, WAddr=0, WData=0, count=0, all cnt=0, BusyVec=0.
  - AluReady=MemReady=1. Stall reflects only the issue inputs, so Stall=0.
  - In-flight FIFO entries are discarded.
- Latency: a push accepted at edge k into an empty FIFO gives Wen=1 in the cycle after edge k+1, i.e. 2 cycles from valid to write.
- Throughput: one register-file write per cycle. Sustained dual pushes are throttled by ready.
- Ready is derived from registered count only and has no combinational path from the Valid inputs.
- Stall is combinational from the issue inputs, cnt and the registered Wen/WAddr.

## Test plan
- Reset mid-operation: push 3 entries, assert Reset during drain → Wen=0, WAddr=0, WData=0, BusyVec=0, AluReady=MemReady=1 immediately; no further writes after Reset drops.
- Simultaneous push: at edge 1, Mem(r3, 0x1111) and Alu(r4, 0x2222) → Wen=1 with r3/0x1111 after edge 2, r4/0x2222 after edge 3, Wen=0 after edge 4.
- Backpressure: hold both Valid high with distinct data for 10 cycles → ready drops whenever count > 2; every accepted entry appears exactly once on WAddr/WData, in order; none lost or duplicated.
- RAW with bypass: issue dest r5, then present RAddr1=5, IssueUsesR1=1 → Stall=1 until the cycle with Wen=1 and WAddr=5, where Stall=0 and the issue is accepted.
- WAW saturation: issue r6 three times → BusyVec[6]=1 and cnt=3; a 4th issue to r6 gives Stall=1; after one write to r6 it is accepted.
- Register zero: push Alu(r0, 0xFFFF) and issue dest 0 → AluReady handshake completes, no Wen pulse, BusyVec unchanged, no Stall from RAddr=0.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// Writeback controller: buffers ALU/load results in a small FIFO, drains one per
// cycle to the register-file write port, and tracks pending writes for RAW/WAW stalls.
module rf_writeback_ctrl #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          AluValid,
  input  logic [3:0]    AluAddr,
  input  logic [DW-1:0] AluData,
  output logic          AluReady,
  input  logic          MemValid,
  input  logic [3:0]    MemAddr,
  input  logic [DW-1:0] MemData,
  output logic          MemReady,
  output logic [3:0]    WAddr,
  output logic [DW-1:0] WData,
  output logic          Wen,
  input  logic          IssueValid,
  input  logic [3:0]    IssueDest,
  input  logic          IssueUsesR1,
  input  logic          IssueUsesR2,
  input  logic [3:0]    RAddr1,
  input  logic [3:0]    RAddr2,
  output logic          Stall,
  output logic [15:0]   BusyVec
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    cnt [16];

  logic          ready;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [CW-1:0] n_push;
  logic [PW-1:0] alu_slot;

  // Ready depends only on registered occupancy so a dual push always fits.
  assign ready    = (count <= CW'(DEPTH - 2));
  assign AluReady = ready;
  assign MemReady = ready;

  // Writes to r0 are accepted but dropped; Mem goes ahead of Alu on a dual push.
  assign mem_push = MemValid && ready && (MemAddr != 4'd0);
  assign alu_push = AluValid && ready && (AluAddr != 4'd0);
  assign pop      = (count != '0);
  assign n_push   = CW'(mem_push) + CW'(alu_push);
  assign alu_slot = wr_ptr + PW'(mem_push);

  always_ff @(posedge Clock) begin
    if (mem_push) fifo_q[wr_ptr]   <= '{addr: MemAddr, data: MemData};
    if (alu_push) fifo_q[alu_slot] <= '{addr: AluAddr, data: AluData};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      Wen    <= 1'b0;
      WAddr  <= '0;
      WData  <= '0;
    end else begin
      if (pop) begin
        Wen    <= 1'b1;
        WAddr  <= fifo_q[rd_ptr].addr;
        WData  <= fifo_q[rd_ptr].data;
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        Wen <= 1'b0;
      end
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count + n_push - CW'(pop);
    end
  end

  logic        hz1;
  logic        hz2;
  logic        issue_inc;
  logic [15:0] inc_vec;
  logic [15:0] dec_vec;

  // A pending write retiring this cycle is covered by the register-file bypass.
  always_comb begin
    hz1 = IssueUsesR1 && (RAddr1 != 4'd0) && (cnt[RAddr1] != 2'd0) &&
          !(Wen && (WAddr == RAddr1) && (cnt[RAddr1] == 2'd1));
    hz2 = IssueUsesR2 && (RAddr2 != 4'd0) && (cnt[RAddr2] != 2'd0) &&
          !(Wen && (WAddr == RAddr2) && (cnt[RAddr2] == 2'd1));
    Stall = IssueValid &&
            (hz1 || hz2 || ((IssueDest != 4'd0) && (cnt[IssueDest] == 2'd3)));
    issue_inc = IssueValid && !Stall && (IssueDest != 4'd0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    BusyVec = '0;
    for (int r = 1; r < 16; r++) begin
      inc_vec[r] = issue_inc && (IssueDest == 4'(r));
      dec_vec[r] = Wen && (WAddr == 4'(r));
      BusyVec[r] = (cnt[r] != 2'd0);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 16; r++) cnt[r] <= 2'd0;
    end else begin
      cnt[0] <= 2'd0;
      for (int r = 1; r < 16; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_rf_writeback_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          AluValid, MemValid, AluReady, MemReady;
  logic [3:0]    AluAddr, MemAddr, WAddr;
  logic [DW-1:0] AluData, MemData, WData;
  logic          Wen;
  logic          IssueValid, IssueUsesR1, IssueUsesR2, Stall;
  logic [3:0]    IssueDest, RAddr1, RAddr2;
  logic [15:0]   BusyVec;

  rf_writeback_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .WAddr(WAddr), .WData(WData), .Wen(Wen),
    .IssueValid(IssueValid), .IssueDest(IssueDest),
    .IssueUsesR1(IssueUsesR1), .IssueUsesR2(IssueUsesR2),
    .RAddr1(RAddr1), .RAddr2(RAddr2),
    .Stall(Stall), .BusyVec(BusyVec)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, per-register pending counts.
  typedef struct { int a; int d; } ent_t;
  ent_t q[$];
  int   mcnt [16];
  int   mwen, mwaddr, mwdata;

  function automatic void model_reset();
    q.delete();
    for (int r = 0; r < 16; r++) mcnt[r] = 0;
    mwen = 0; mwaddr = 0; mwdata = 0;
  endfunction

  function automatic bit m_hz(int u, int ra);
    return (u != 0) && (ra != 0) && (mcnt[ra] != 0) &&
           !((mwen != 0) && (mwaddr == ra) && (mcnt[ra] == 1));
  endfunction

  function automatic bit m_stall(int iv, int id, int u1, int r1, int u2, int r2);
    return (iv != 0) && (m_hz(u1, r1) || m_hz(u2, r2) || ((id != 0) && (mcnt[id] == 3)));
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    for (int r = 1; r < 16; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic drive(input int mv, input int ma, input int md, input int av, input int aa,
                       input int ad, input int iv, input int id, input int u1, input int r1,
                       input int u2, input int r2);
    MemValid = 1'(mv); MemAddr = 4'(ma); MemData = DW'(md);
    AluValid = 1'(av); AluAddr = 4'(aa); AluData = DW'(ad);
    IssueValid = 1'(iv); IssueDest = 4'(id);
    IssueUsesR1 = 1'(u1); RAddr1 = 4'(r1); IssueUsesR2 = 1'(u2); RAddr2 = 4'(r2);
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: drive, check against model, then advance model over the edge.
  task automatic step(input int mv, input int ma, input int md, input int av, input int aa,
                      input int ad, input int iv, input int id, input int u1, input int r1,
                      input int u2, input int r2, output bit st);
    bit rdy;
    int owen, owaddr;
    ent_t e;
    @(negedge Clock);
    drive(mv, ma, md, av, aa, ad, iv, id, u1, r1, u2, r2);
    #1;
    rdy = (q.size() <= DEPTH - 2);
    st  = m_stall(iv, id, u1, r1, u2, r2);
    chk("wen",   32'(Wen),      32'(mwen));
    chk("waddr", 32'(WAddr),    32'(mwaddr));
    chk("wdata", 32'(WData),    32'(mwdata));
    chk("ready", {30'd0, AluReady, MemReady}, {30'd0, rdy, rdy});
    chk("stall", 32'(Stall),    32'(st));
    chk("busy",  32'(BusyVec),  32'(m_busy()));
    owen = mwen; owaddr = mwaddr;
    if (q.size() > 0) begin
      e = q.pop_front();
      mwen = 1; mwaddr = e.a; mwdata = e.d;
    end else begin
      mwen = 0;
    end
    if (mv != 0 && rdy && ma != 0) q.push_back('{ma, md});
    if (av != 0 && rdy && aa != 0) q.push_back('{aa, ad});
    for (int r = 1; r < 16; r++) begin
      bit inc = (iv != 0) && !st && (id == r);
      bit dec = (owen != 0) && (owaddr == r);
      if (inc && !dec) mcnt[r]++;
      else if (dec && !inc && mcnt[r] > 0) mcnt[r]--;
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    idle_inputs();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int mv, ma, md, av, aa, ad, iv, id, u1, r1;
    int wen, wa, wd, rdy, st, busy;
  } vec_t;

  vec_t vt [11];
  bit   st;
  bit   accepted;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_wen",   32'(Wen), 0);
    chk("rst_waddr", 32'(WAddr), 0);
    chk("rst_wdata", 32'(WData), 0);
    chk("rst_busy",  32'(BusyVec), 0);
    chk("rst_ready", {30'd0, AluReady, MemReady}, 32'd3);
    chk("rst_stall", 32'(Stall), 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Dual push ordering, then RAW with bypass release on r5.
    //          mv ma md       av aa ad       iv id u1 r1  wen wa wd       rdy st busy
    vt[0]  = '{1, 3, 'h1111, 1, 4, 'h2222, 0, 0, 0, 0,  0, 0, 'h0000, 1, 0, 'h0000};
    vt[1]  = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 0,  0, 0, 'h0000, 1, 0, 'h0000};
    vt[2]  = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 0,  1, 3, 'h1111, 1, 0, 'h0000};
    vt[3]  = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 0,  1, 4, 'h2222, 1, 0, 'h0000};
    vt[4]  = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 0,  0, 4, 'h2222, 1, 0, 'h0000};
    vt[5]  = '{0, 0, 0,      0, 0, 0,      1, 5, 0, 0,  0, 4, 'h2222, 1, 0, 'h0000};
    vt[6]  = '{0, 0, 0,      0, 0, 0,      1, 0, 1, 5,  0, 4, 'h2222, 1, 1, 'h0020};
    vt[7]  = '{0, 0, 0,      1, 5, 'hABCD, 1, 0, 1, 5,  0, 4, 'h2222, 1, 1, 'h0020};
    vt[8]  = '{0, 0, 0,      0, 0, 0,      1, 0, 1, 5,  0, 4, 'h2222, 1, 1, 'h0020};
    vt[9]  = '{0, 0, 0,      0, 0, 0,      1, 0, 1, 5,  1, 5, 'hABCD, 1, 0, 'h0020};
    vt[10] = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 0,  0, 5, 'hABCD, 1, 0, 'h0000};
    for (int i = 0; i < 11; i++) begin
      @(negedge Clock);
      drive(vt[i].mv, vt[i].ma, vt[i].md, vt[i].av, vt[i].aa, vt[i].ad,
            vt[i].iv, vt[i].id, vt[i].u1, vt[i].r1, 0, 0);
      #1;
      chk($sformatf("vec%0d_wen", i),   32'(Wen),     32'(vt[i].wen));
      chk($sformatf("vec%0d_waddr", i), 32'(WAddr),   32'(vt[i].wa));
      chk($sformatf("vec%0d_wdata", i), 32'(WData),   32'(vt[i].wd));
      chk($sformatf("vec%0d_ready", i), 32'(AluReady && MemReady), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_stall", i), 32'(Stall),   32'(vt[i].st));
      chk($sformatf("vec%0d_busy", i),  32'(BusyVec), 32'(vt[i].busy));
    end

    // Reset in the middle of a drain.
    do_reset();
    step(1, 7, 'h0707, 1, 8, 'h0808, 1, 7, 0, 0, 0, 0, st);
    step(1, 9, 'h0909, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    @(negedge Clock);
    idle_inputs();
    #2;
    chk("pre_mrst_wen", 32'(Wen), 1);
    Reset = 1'b1;
    #1;
    chk("mrst_wen",   32'(Wen), 0);
    chk("mrst_waddr", 32'(WAddr), 0);
    chk("mrst_wdata", 32'(WData), 0);
    chk("mrst_busy",  32'(BusyVec), 0);
    chk("mrst_ready", {30'd0, AluReady, MemReady}, 32'd3);
    chk("mrst_stall", 32'(Stall), 0);
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    model_reset();
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    // WAW saturation on r6.
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, st);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, st);
    chk("waw_4th_stall", 32'(st), 1);
    step(0, 0, 0, 1, 6, 'h6666, 1, 6, 0, 0, 0, 0, st);
    accepted = 1'b0;
    for (int k = 0; k < 6 && !accepted; k++) begin
      step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, st);
      accepted = !st;
    end
    chk("waw_accept_after_write", 32'(accepted), 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    // Register zero: handshake completes but nothing is written or tracked.
    do_reset();
    step(0, 0, 0, 1, 0, 'hFFFF, 1, 0, 1, 0, 1, 0, st);
    chk("r0_stall", 32'(st), 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    // Backpressure: both sources valid for 10 cycles with distinct data.
    for (int k = 0; k < 10; k++)
      step(1, 1 + (k % 15), 'h1000 + k, 1, 15 - (k % 15), 'h2000 + k, 0, 0, 0, 0, 0, 0, st);
    repeat (8) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom & 16'hFFFF),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom & 16'hFFFF),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), st);
    end
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
